// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and the width-generic extension function for the
// ID/EX immediate stage.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN = 2'd0;
  localparam logic [1:0] MODE_ZERO = 2'd1;
  localparam logic [1:0] MODE_LUI  = 2'd2;
  localparam logic [1:0] MODE_BR   = 2'd3;

  localparam int MAX_W = 64;

  // imm arrives zero-padded to MAX_W; callers keep only the low out_w bits.
  function automatic logic [MAX_W-1:0] ext_f(input logic [MAX_W-1:0] imm,
                                             input logic [1:0]       mode,
                                             input int               in_w,
                                             input int               out_w);
    logic             sign;
    logic [MAX_W-1:0] sx;
    sign = |(imm & (MAX_W'(1) << (in_w - 1)));
    sx   = sign ? (imm | ({MAX_W{1'b1}} << in_w)) : imm;
    case (mode)
      MODE_SIGN: ext_f = sx;
      MODE_ZERO: ext_f = imm;
      MODE_LUI:  ext_f = imm << (out_w - in_w);
      default:   ext_f = sx << 2;
    endcase
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus for the immediate-extension stage: input beat side plus
// extended-result side.
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; one instance sits on the input side so
// the pipeline registers only ever hold finished results.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  assign ext = OUT_W'(ext_f(MAX_W'(imm), mode, IN_W, OUT_W));

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a main output register and a
// skid register, so back-pressure never loses or repeats a beat.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  imm_extend_pipe_if.slave  bus
);

  if (IN_W < 2 || OUT_W < IN_W + 2 || OUT_W > MAX_W) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W combination");
  end

  logic             m_valid_reg;
  logic [OUT_W-1:0] m_data_reg;
  logic [1:0]       m_mode_reg;
  logic             s_valid_reg;
  logic [OUT_W-1:0] s_data_reg;
  logic [1:0]       s_mode_reg;
  logic [OUT_W-1:0] ext_data;
  logic             accept;
  logic             m_free;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext_data)
  );

  // in_ready comes straight from the skid flop, keeping it off any comb path.
  assign bus.in_ready  = !s_valid_reg;
  assign accept        = bus.in_valid && !s_valid_reg;
  assign m_free        = !m_valid_reg || bus.out_ready;

  assign bus.out_valid = m_valid_reg;
  assign bus.out_data  = m_data_reg;
  assign bus.out_mode  = m_mode_reg;

  always_ff @(posedge Clk) begin
    if (!Rst || Flush) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_mode_reg  <= '0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_mode_reg  <= '0;
    end else if (m_free) begin
      // Skid content is older than any new beat, so it wins the move into M.
      if (s_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= s_data_reg;
        m_mode_reg  <= s_mode_reg;
        s_valid_reg <= 1'b0;
      end else if (accept) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= ext_data;
        m_mode_reg  <= bus.in_mode;
      end else begin
        m_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      s_valid_reg <= 1'b1;
      s_data_reg  <= ext_data;
      s_mode_reg  <= bus.in_mode;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: 16->32 instance for handshake,
// flush and reset behaviour, plus an 8->16 instance for the width sweep.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    int          stamp;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t sb8[$];

  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [1:0]  hold_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) bus8 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .Clk (clk), .Rst (rst), .Flush (flush), .bus (bus)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .Clk (clk), .Rst (rst), .Flush (flush), .bus (bus8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] sx;
    sx = {{16{imm[15]}}, imm};
    case (mode)
      2'd0:    return sx;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {sx[29:0], 2'b00};
    endcase
  endfunction

  // Sample 2 time units after the falling edge: these are the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      if (hold_v) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(hold_d));
        check("hold_mode", 64'(bus.out_mode), 64'(hold_m));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(bus.out_data), 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = sb.pop_front();
          $display("out16 data=%h mode=%0d exp=%h cyc=%0d", bus.out_data, bus.out_mode, e.data, cyc);
          check("data", 64'(bus.out_data), 64'(e.data));
          check("mode", 64'(bus.out_mode), 64'(e.mode));
          if (e.lat) check("latency", 64'(cyc), 64'(e.stamp + 1));
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (sb8.size() == 0) begin
          check("unexpected_out8", 64'(bus8.out_data), 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          e = sb8.pop_front();
          $display("out8  data=%h mode=%0d exp=%h cyc=%0d", bus8.out_data, bus8.out_mode, e.data[15:0], cyc);
          check("data8", 64'(bus8.out_data), 64'(e.data[15:0]));
          check("mode8", 64'(bus8.out_mode), 64'(e.mode));
          if (e.lat) check("latency8", 64'(cyc), 64'(e.stamp + 1));
        end
      end
    end
    hold_v = rst && !flush && bus.out_valid && !bus.out_ready;
    hold_d = bus.out_data;
    hold_m = bus.out_mode;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [31:0] exp, input bit lat);
    int budget;
    budget = 50;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    while (!bus.in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    else sb.push_back('{data: exp, mode: mode, stamp: cyc, lat: lat});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] imm, input logic [1:0] mode, input logic [15:0] exp);
    bus8.in_valid = 1'b1;
    bus8.in_imm   = imm;
    bus8.in_mode  = mode;
    if (!bus8.in_ready) check("accept8_ready", 64'(bus8.in_ready), 64'd1);
    else sb8.push_back('{data: 32'(exp), mode: mode, stamp: cyc, lat: 1'b1});
    tick();
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while ((sb.size() != 0 || sb8.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain16", 64'(sb.size()), 64'd0);
    check("drain8", 64'(sb8.size()), 64'd0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] rimm;
    logic [1:0]  rmode;

    // Reset held for two edges with a beat offered.
    bus.in_valid  = 1'b1;
    bus.in_imm    = 16'h1234;
    bus.in_mode   = MODE_SIGN;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_imm   = '0;
    bus8.in_mode  = MODE_SIGN;
    bus8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    bus.in_valid = 1'b0;
    check_empty("reset");
    check("reset_out_data", 64'(bus.out_data), 64'd0);
    check("reset_out_mode", 64'(bus.out_mode), 64'd0);
    check("reset_out_valid8", 64'(bus8.out_valid), 64'd0);
    rst = 1'b1;
    tick();
    check_empty("post_reset");

    // Back-to-back streaming, one of each mode.
    send(16'h8004, MODE_SIGN, 32'hFFFF8004, 1'b1);
    send(16'h8004, MODE_ZERO, 32'h00008004, 1'b1);
    send(16'h1234, MODE_LUI,  32'h12340000, 1'b1);
    send(16'hFFFF, MODE_BR,   32'hFFFFFFFC, 1'b1);
    drain();

    // Backpressure fills M then S.
    bus.out_ready = 1'b0;
    send(16'h0001, MODE_SIGN, 32'h00000001, 1'b0);
    send(16'h0002, MODE_SIGN, 32'h00000002, 1'b0);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_a_held", 64'(bus.out_data), 64'h1);
    repeat (3) tick();
    bus.out_ready = 1'b1;
    tick();
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("bp_b_next", 64'(bus.out_data), 64'h2);
    drain();

    // Flush with M and S full while C is offered.
    bus.out_ready = 1'b0;
    send(16'h0003, MODE_ZERO, 32'h00000003, 1'b0);
    send(16'h0004, MODE_ZERO, 32'h00000004, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h0005;
    bus.in_mode  = MODE_ZERO;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check_empty("flush_full");
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Flush with only M full: C sees in_ready=1 yet must still be dropped.
    bus.out_ready = 1'b0;
    send(16'h0006, MODE_LUI, 32'h00060000, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h0007;
    bus.in_mode  = MODE_LUI;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check_empty("flush_m");
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Reset mid-transfer with S full and downstream stalled.
    bus.out_ready = 1'b0;
    send(16'h0008, MODE_SIGN, 32'h00000008, 1'b0);
    send(16'h0009, MODE_SIGN, 32'h00000009, 1'b0);
    rst = 1'b0;
    tick();
    check_empty("midreset");
    check("midreset_out_data", 64'(bus.out_data), 64'd0);
    check("midreset_out_mode", 64'(bus.out_mode), 64'd0);
    sb.delete();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    send(16'hF00D, MODE_BR, 32'hFFFFC034, 1'b1);
    drain();

    // Narrow instance.
    send8(8'h80, MODE_SIGN, 16'hFF80);
    send8(8'hAB, MODE_LUI,  16'hAB00);
    send8(8'h7F, MODE_BR,   16'h01FC);
    send8(8'h80, MODE_ZERO, 16'h0080);
    drain();

    // Random traffic with random downstream stalls.
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready && $urandom_range(0, 2) != 0) begin
        rimm  = 16'($urandom);
        rmode = 2'($urandom_range(0, 3));
        bus.in_valid = 1'b1;
        bus.in_imm   = rimm;
        bus.in_mode  = rmode;
        sb.push_back('{data: model32(rimm, rmode), mode: rmode, stamp: cyc, lat: 1'b0});
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
